modport_bridge: RTL and testbench

- AHB-Lite slave to APB master bridge. It sits between the AHB system bus and up to four APB peripherals.
- Converts each AHB single or pipelined transfer into a two-phase APB transfer (SETUP, then ENABLE).
- Inserts AHB wait states through Hreadyout while APB accesses complete.
- Decodes the address into one-hot peripheral selects.

---
 rtl/bridge_pkg.sv | 37 +++
 rtl/modport_bridge_if.sv | 38 +++
 rtl/ahb_slave_if.sv | 95 +++++++++
 rtl/modport_bridge.sv | 156 +++++++++++++++
 tb/tb_modport_bridge.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
//   state_e  : APB-side FSM states
//   htrans_e : AHB transfer type encodings
//   DEC_*    : peripheral address window and per-slave slot size
//   HRESP_OKAY : the only response the bridge ever returns
package bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWwait,
        StRead,
        StWrite,
        StWritep,
        StRenable,
        StWenable,
        StWenablep
    } state_e;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    // Peripheral window, split into 64 MiB slots, one per APB slave.
    localparam logic [31:0]  DEC_BASE       = 32'h8000_0000;
    localparam logic [31:0]  DEC_LIMIT      = 32'h8FFF_FFFF;
    localparam int unsigned  DEC_SLOT_SHIFT = 26;

    function automatic logic addr_in_window(input logic [31:0] addr);
        return (addr >= DEC_BASE) && (addr <= DEC_LIMIT);
    endfunction

endpackage

// File: rtl/modport_bridge_if.sv
// Bus bundle between the AHB master / APB peripherals and the bridge.
//   AHB side : Htrans, Hsize, Hreadyin, Hwrite, Haddr, Hwdata -> bridge
//              Hrdata, Hresp, Hreadyout                        <- bridge
//   APB side : Pselx, Pwrite, Penable, Paddr, Pwdata          <- bridge
//              Prdata                                          -> bridge
// Modports: slave = bridge view (AHB slave, APB master),
//           master = environment view (AHB master plus APB peripherals).
interface modport_bridge_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SLAVES = 4
);
    logic [1:0]        Htrans;
    logic [2:0]        Hsize;
    logic              Hreadyin;
    logic              Hwrite;
    logic [WIDTH-1:0]  Haddr;
    logic [WIDTH-1:0]  Hwdata;
    logic [WIDTH-1:0]  Hrdata;
    logic [1:0]        Hresp;
    logic              Hreadyout;
    logic [SLAVES-1:0] Pselx;
    logic              Pwrite;
    logic              Penable;
    logic [WIDTH-1:0]  Paddr;
    logic [WIDTH-1:0]  Pwdata;
    logic [WIDTH-1:0]  Prdata;

    modport slave (
        input  Htrans, Hsize, Hreadyin, Hwrite, Haddr, Hwdata, Prdata,
        output Hrdata, Hresp, Hreadyout, Pselx, Pwrite, Penable, Paddr, Pwdata
    );

    modport master (
        output Htrans, Hsize, Hreadyin, Hwrite, Haddr, Hwdata, Prdata,
        input  Hrdata, Hresp, Hreadyout, Pselx, Pwrite, Penable, Paddr, Pwdata
    );

endinterface

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the bridge: address/data pipeline, transfer
// qualification and peripheral select decode.
//   Hclk, Hresetn     : clock, synchronous active-high reset
//   htrans_i .. hwdata_i : raw AHB inputs
//   valid_o           : live, in-window NONSEQ/SEQ transfer while the bus is ready
//   tempselx_o        : one-hot select decoded from the live address
//   selx1_o           : select registered alongside Haddr1
//   haddr1_o          : address of the transfer now in its data phase
//   haddr2_next_o     : value Haddr2 captures on the coming edge
//   hwdata1_next_o    : value Hwdata1 captures on the coming edge
//   hwritereg_o       : direction registered alongside Haddr1
module ahb_slave_if
    import bridge_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SLAVES = 4
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic [1:0]        htrans_i,
    input  logic              hreadyin_i,
    input  logic              hwrite_i,
    input  logic [WIDTH-1:0]  haddr_i,
    input  logic [WIDTH-1:0]  hwdata_i,
    output logic              valid_o,
    output logic [SLAVES-1:0] tempselx_o,
    output logic [SLAVES-1:0] selx1_o,
    output logic [WIDTH-1:0]  haddr1_o,
    output logic [WIDTH-1:0]  haddr2_next_o,
    output logic [WIDTH-1:0]  hwdata1_next_o,
    output logic              hwritereg_o
);

    logic [WIDTH-1:0]  haddr1_q, haddr1_d;
    logic [WIDTH-1:0]  haddr2_q, haddr2_d;
    logic [WIDTH-1:0]  hwdata1_q, hwdata1_d;
    logic              hwritereg_q, hwritereg_d;
    logic [SLAVES-1:0] selx1_q, selx1_d;

    logic              in_win;
    logic [WIDTH-1:0]  offset;

    // Decode and qualification.
    always_comb begin
        in_win     = addr_in_window(haddr_i);
        offset     = haddr_i - DEC_BASE;
        tempselx_o = '0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            if (in_win && ((offset >> DEC_SLOT_SHIFT) == WIDTH'(i))) begin
                tempselx_o[i] = 1'b1;
            end
        end
        // Htrans[1] is set only for NONSEQ and SEQ.
        valid_o = hreadyin_i & htrans_i[1] & in_win;
    end

    // Pipeline advances only while the AHB bus is ready.
    always_comb begin
        haddr1_d    = haddr1_q;
        haddr2_d    = haddr2_q;
        hwdata1_d   = hwdata1_q;
        hwritereg_d = hwritereg_q;
        selx1_d     = selx1_q;
        if (hreadyin_i) begin
            haddr1_d    = haddr_i;
            haddr2_d    = haddr1_q;
            hwdata1_d   = hwdata_i;
            hwritereg_d = hwrite_i;
            selx1_d     = tempselx_o;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hresetn) begin
            haddr1_q    <= '0;
            haddr2_q    <= '0;
            hwdata1_q   <= '0;
            hwritereg_q <= 1'b0;
            selx1_q     <= '0;
        end else begin
            haddr1_q    <= haddr1_d;
            haddr2_q    <= haddr2_d;
            hwdata1_q   <= hwdata1_d;
            hwritereg_q <= hwritereg_d;
            selx1_q     <= selx1_d;
        end
    end

    assign selx1_o        = selx1_q;
    assign haddr1_o       = haddr1_q;
    assign haddr2_next_o  = haddr2_d;
    assign hwdata1_next_o = hwdata1_d;
    assign hwritereg_o    = hwritereg_q;

endmodule

// File: rtl/modport_bridge.sv
// AHB-Lite slave to APB master bridge for up to SLAVES peripherals.
// Each AHB transfer becomes an APB SETUP then ENABLE phase; Hreadyout is
// dropped to stall the AHB master while an APB access is outstanding.
//   Hclk    : clock, all state on the rising edge
//   Hresetn : synchronous reset, active high
//   bus     : modport_bridge_if.slave, carries every AHB and APB signal
module modport_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SLAVES = 4
) (
    input  logic            Hclk,
    input  logic            Hresetn,
    modport_bridge_if.slave bus
);

    state_e state_q, state_d;

    logic              valid;
    logic              hwritereg;
    logic [SLAVES-1:0] tempselx;
    logic [SLAVES-1:0] selx1;
    logic [WIDTH-1:0]  haddr1;
    logic [WIDTH-1:0]  haddr2_next;
    logic [WIDTH-1:0]  hwdata1_next;

    logic [SLAVES-1:0] pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [WIDTH-1:0]  paddr_q, paddr_d;
    logic [WIDTH-1:0]  pwdata_q, pwdata_d;
    logic              hreadyout_q, hreadyout_d;

    ahb_slave_if #(
        .WIDTH  (WIDTH),
        .SLAVES (SLAVES)
    ) u_ahb_slave_if (
        .Hclk           (Hclk),
        .Hresetn        (Hresetn),
        .htrans_i       (bus.Htrans),
        .hreadyin_i     (bus.Hreadyin),
        .hwrite_i       (bus.Hwrite),
        .haddr_i        (bus.Haddr),
        .hwdata_i       (bus.Hwdata),
        .valid_o        (valid),
        .tempselx_o     (tempselx),
        .selx1_o        (selx1),
        .haddr1_o       (haddr1),
        .haddr2_next_o  (haddr2_next),
        .hwdata1_next_o (hwdata1_next),
        .hwritereg_o    (hwritereg)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (valid) state_d = bus.Hwrite ? StWwait : StRead;
            end
            StWwait:  state_d = valid ? StWritep : StWrite;
            StRead:   state_d = StRenable;
            StWrite:  state_d = valid ? StWenablep : StWenable;
            StWritep: state_d = StWenablep;
            StRenable, StWenable: begin
                if (valid) state_d = bus.Hwrite ? StWwait : StRead;
                else       state_d = StIdle;
            end
            StWenablep: begin
                if (!hwritereg) state_d = StRead;
                else            state_d = valid ? StWritep : StWrite;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are loaded according to the state being entered.
    always_comb begin
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;
        unique case (state_d)
            StIdle, StWwait: begin
                pselx_d     = '0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
            StRead: begin
                pselx_d     = tempselx;
                paddr_d     = bus.Haddr;
                pwrite_d    = 1'b0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            StWrite: begin
                pselx_d     = selx1;
                paddr_d     = haddr1;
                pwdata_d    = bus.Hwdata;
                pwrite_d    = 1'b1;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
            StWritep: begin
                // WRITEP is only entered while Hreadyin is high, so the second
                // pipeline stage is capturing the older transfer on this edge.
                pselx_d     = selx1;
                paddr_d     = haddr2_next;
                pwdata_d    = hwdata1_next;
                pwrite_d    = 1'b1;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            StRenable, StWenable, StWenablep: begin
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end
            default: begin
                pselx_d = pselx_q;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hresetn) begin
            state_q     <= StIdle;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Hreadyout = hreadyout_q;
    assign bus.Hresp     = HRESP_OKAY;
    assign bus.Hrdata    = bus.Prdata;

endmodule

// File: tb/tb_modport_bridge.sv
// Cycle-vector bench for modport_bridge. Each vector holds the inputs for one
// cycle and the outputs expected just after the following rising edge.
module tb_modport_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hr_en = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    modport_bridge_if #(.WIDTH(32), .SLAVES(4)) bus ();

    // Hreadyin follows the bridge's own Hreadyout, as on a single-slave bus.
    assign bus.Hreadyin = bus.Hreadyout & hr_en;

    modport_bridge #(
        .WIDTH  (32),
        .SLAVES (4)
    ) dut (
        .Hclk    (clk),
        .Hresetn (rst),
        .bus     (bus)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  htrans;
        logic        hwrite;
        logic        hr_en;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        logic [3:0]  psel;
        logic        pen;
        logic        hro;
        logic        chk_ap;   // check Pwrite and Paddr
        logic        chk_wd;   // check Pwdata
        logic        pw;
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } vec_t;

    typedef struct {
        logic [3:0]  psel;
        logic        pen;
        logic        hro;
        logic        chk_ap;
        logic        chk_wd;
        logic        pw;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [31:0] hrdata;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[23];

    function automatic vec_t mk(
        input logic rst_v, input logic [1:0] htrans, input logic hwrite, input logic hren,
        input logic [31:0] haddr, input logic [31:0] hwdata, input logic [31:0] prdata,
        input logic [3:0] psel, input logic pen, input logic hro, input logic chk_ap,
        input logic chk_wd, input logic pw, input logic [31:0] paddr,
        input logic [31:0] pwdata);
        vec_t v;
        v.rst = rst_v;   v.htrans = htrans; v.hwrite = hwrite; v.hr_en = hren;
        v.haddr = haddr; v.hwdata = hwdata; v.prdata = prdata;
        v.psel = psel;   v.pen = pen;       v.hro = hro;
        v.chk_ap = chk_ap; v.chk_wd = chk_wd; v.pw = pw;
        v.paddr = paddr; v.pwdata = pwdata;
        return v;
    endfunction

    // Idle cycle expecting the bridge parked in IDLE (Pselx 0, ready).
    function automatic vec_t idle_v(input logic [31:0] prdata);
        return mk(0, 2'b00, 0, 1, 32'h0, 32'h0, prdata, 4'h0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %h, expected %h", tag, what, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        rst        = v.rst;
        hr_en      = v.hr_en;
        bus.Htrans = v.htrans;
        bus.Hwrite = v.hwrite;
        bus.Hsize  = 3'b010;
        bus.Haddr  = v.haddr;
        bus.Hwdata = v.hwdata;
        bus.Prdata = v.prdata;
        e.psel = v.psel; e.pen = v.pen; e.hro = v.hro; e.chk_ap = v.chk_ap;
        e.chk_wd = v.chk_wd; e.pw = v.pw; e.paddr = v.paddr; e.pwdata = v.pwdata;
        e.hrdata = v.prdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(tag, "Pselx", 32'(bus.Pselx), 32'(e.psel));
        chk(tag, "Penable", 32'(bus.Penable), 32'(e.pen));
        chk(tag, "Hreadyout", 32'(bus.Hreadyout), 32'(e.hro));
        chk(tag, "Hresp", 32'(bus.Hresp), 32'h0);
        chk(tag, "Hrdata", bus.Hrdata, e.hrdata);
        if (e.chk_ap) begin
            chk(tag, "Pwrite", 32'(bus.Pwrite), 32'(e.pw));
            chk(tag, "Paddr", bus.Paddr, e.paddr);
        end
        if (e.chk_wd) chk(tag, "Pwdata", bus.Pwdata, e.pwdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles.
        tbl[0]  = mk(1, 2'b00, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 1, 0, 32'h0, 32'h0);
        tbl[1]  = tbl[0];
        // Single read.
        tbl[2]  = mk(0, 2'b10, 0, 1, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF,
                     4'h1, 0, 0, 1, 0, 0, 32'h8000_0010, 32'h0);
        tbl[3]  = mk(0, 2'b00, 0, 1, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF,
                     4'h1, 1, 1, 1, 0, 0, 32'h8000_0010, 32'h0);
        tbl[4]  = idle_v(32'hDEAD_BEEF);
        // Single write: WWAIT, WRITE, WENABLE.
        tbl[5]  = mk(0, 2'b10, 1, 1, 32'h8400_0004, 32'h0, 32'h0,
                     4'h0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[6]  = mk(0, 2'b00, 0, 1, 32'h0, 32'h1234_5678, 32'h0,
                     4'h2, 0, 1, 1, 1, 1, 32'h8400_0004, 32'h1234_5678);
        tbl[7]  = mk(0, 2'b00, 0, 1, 32'h0, 32'h0, 32'h0,
                     4'h2, 1, 1, 1, 1, 1, 32'h8400_0004, 32'h1234_5678);
        tbl[8]  = idle_v(32'h0);
        // Back-to-back writes: WWAIT, WRITEP, WENABLEP, WRITE, WENABLE.
        tbl[9]  = mk(0, 2'b10, 1, 1, 32'h8800_0000, 32'h0, 32'h0,
                     4'h0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[10] = mk(0, 2'b11, 1, 1, 32'h8800_0004, 32'hAAAA_0001, 32'h0,
                     4'h4, 0, 0, 1, 1, 1, 32'h8800_0000, 32'hAAAA_0001);
        tbl[11] = mk(0, 2'b00, 0, 1, 32'h0, 32'hBBBB_0002, 32'h0,
                     4'h4, 1, 1, 1, 1, 1, 32'h8800_0000, 32'hAAAA_0001);
        tbl[12] = mk(0, 2'b00, 0, 1, 32'h0, 32'hBBBB_0002, 32'h0,
                     4'h4, 0, 1, 1, 1, 1, 32'h8800_0004, 32'hBBBB_0002);
        tbl[13] = mk(0, 2'b00, 0, 1, 32'h0, 32'h0, 32'h0,
                     4'h4, 1, 1, 1, 1, 1, 32'h8800_0004, 32'hBBBB_0002);
        tbl[14] = idle_v(32'h0);
        // Out-of-range, BUSY and not-ready transfers are all ignored.
        tbl[15] = mk(0, 2'b10, 0, 1, 32'h9000_0000, 32'h0, 32'h0,
                     4'h0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[16] = idle_v(32'h0);
        tbl[17] = mk(0, 2'b01, 0, 1, 32'h8000_0000, 32'h0, 32'h0,
                     4'h0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[18] = mk(0, 2'b10, 0, 0, 32'h8C00_0000, 32'h0, 32'h0,
                     4'h0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        // Read from the top slot, then reset during RENABLE.
        tbl[19] = mk(0, 2'b10, 0, 1, 32'h8C00_0100, 32'h0, 32'h5A5A_5A5A,
                     4'h8, 0, 0, 1, 0, 0, 32'h8C00_0100, 32'h0);
        tbl[20] = mk(0, 2'b00, 0, 1, 32'h0, 32'h0, 32'h5A5A_5A5A,
                     4'h8, 1, 1, 1, 0, 0, 32'h8C00_0100, 32'h0);
        tbl[21] = mk(1, 2'b10, 1, 1, 32'h8000_0000, 32'h0, 32'h0,
                     4'h0, 0, 1, 1, 1, 0, 32'h0, 32'h0);
        tbl[22] = mk(0, 2'b00, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 0, 1, 1, 1, 0, 32'h0, 32'h0);

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Write, then a read issued during WENABLE, then a read during RENABLE.
        apply(mk(0, 2'b10, 1, 1, 32'h8000_0008, 32'h0, 32'h0,
                 4'h0, 0, 1, 0, 0, 0, 32'h0, 32'h0), "seq_w_wwait");
        apply(mk(0, 2'b00, 0, 1, 32'h0, 32'h1111_2222, 32'h0,
                 4'h1, 0, 1, 1, 1, 1, 32'h8000_0008, 32'h1111_2222), "seq_w_write");
        apply(mk(0, 2'b00, 0, 1, 32'h0, 32'h0, 32'h0,
                 4'h1, 1, 1, 1, 1, 1, 32'h8000_0008, 32'h1111_2222), "seq_w_enable");
        apply(mk(0, 2'b10, 0, 1, 32'h8800_0040, 32'h0, 32'hCAFE_0001,
                 4'h4, 0, 0, 1, 0, 0, 32'h8800_0040, 32'h0), "seq_r1_read");
        apply(mk(0, 2'b00, 0, 1, 32'h0, 32'h0, 32'hCAFE_0001,
                 4'h4, 1, 1, 1, 0, 0, 32'h8800_0040, 32'h0), "seq_r1_enable");
        apply(mk(0, 2'b10, 0, 1, 32'h8400_0030, 32'h0, 32'hCAFE_0002,
                 4'h2, 0, 0, 1, 0, 0, 32'h8400_0030, 32'h0), "seq_r2_read");
        apply(mk(0, 2'b00, 0, 1, 32'h0, 32'h0, 32'hCAFE_0002,
                 4'h2, 1, 1, 1, 0, 0, 32'h8400_0030, 32'h0), "seq_r2_enable");
        apply(idle_v(32'h0), "seq_idle");

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
